// File: rtl/popcount_serial_multi_pkg.sv
// rtl/popcount_serial_multi_pkg.sv - shared state type and width helpers for the serial popcount block
package popcount_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest slice step_popcount can examine; STEP must not exceed it.
  localparam int MAX_SLICE = 64;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int total_w(input int width, input int channels);
    return $clog2(width * channels + 1);
  endfunction

  function automatic int cycles_w(input int width, input int step);
    return $clog2((width + step - 1) / step + 1);
  endfunction

  function automatic logic [31:0] step_popcount(input logic [MAX_SLICE-1:0] slice, input int step);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_SLICE; i++) begin
      if (i < step && slice[i]) begin
        n = n + 32'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/popcount_serial_multi_if.sv
// rtl/popcount_serial_multi_if.sv - word-set input and result output handshakes of the popcount block
interface popcount_serial_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STEP     = 1
);
  localparam int CW = popcount_pkg::cnt_w(WIDTH);
  localparam int TW = popcount_pkg::total_w(WIDTH, CHANNELS);
  localparam int YW = popcount_pkg::cycles_w(WIDTH, STEP);

  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CHANNELS*CW-1:0]   out_count;
  logic [TW-1:0]            out_total;
  logic [YW-1:0]            out_cycles;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_total, out_cycles
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_total, out_cycles
  );

endinterface

// File: rtl/popcount_serial_multi_lane.sv
// rtl/popcount_serial_multi_lane.sv - one lane: shift register consumed STEP bits per advance, plus running count
module popcount_lane
  import popcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int CW   = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_advance,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_count_next,
  output logic             o_remaining_zero
);

  logic [WIDTH-1:0]     r_shift;
  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     w_shift_next;
  logic [MAX_SLICE-1:0] w_slice;

  // Bits above WIDTH in the last slice are zero-filled by the shift, so padding is implicit.
  always_comb begin
    w_slice              = '0;
    w_slice[STEP-1:0]    = r_shift[STEP-1:0];
    w_shift_next         = r_shift >> STEP;
    o_count_next         = r_count + CW'(step_popcount(w_slice, STEP));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shift <= i_load_data;
      r_count <= '0;
    end else if (i_advance) begin
      r_shift <= w_shift_next;
      r_count <= o_count_next;
    end
  end

  assign o_count          = r_count;
  assign o_remaining_zero = (w_shift_next == '0);

endmodule

// File: rtl/popcount_serial_multi.sv
// rtl/popcount_serial_multi.sv - multi-lane serial population counter with early termination
module popcount_serial_multi
  import popcount_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STEP     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  popcount_serial_multi_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam int TW = total_w(WIDTH, CHANNELS);
  localparam int YW = cycles_w(WIDTH, STEP);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    w_load;
  logic                    w_advance;
  logic                    w_all_zero;
  logic [CW-1:0]           w_count      [CHANNELS];
  logic [CW-1:0]           w_count_next [CHANNELS];
  logic [CHANNELS-1:0]     w_lane_zero;
  logic [CHANNELS*CW-1:0]  w_count_flat;
  logic [TW-1:0]           w_total_next;
  logic [TW-1:0]           r_total;
  logic [YW-1:0]           r_cycles;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    popcount_lane #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_lane (
      .clk              (clk),
      .rst              (rst),
      .i_load           (w_load),
      .i_load_data      (bus.in_data[g*WIDTH +: WIDTH]),
      .i_advance        (w_advance),
      .o_count          (w_count[g]),
      .o_count_next     (w_count_next[g]),
      .o_remaining_zero (w_lane_zero[g])
    );
  end

  always_comb begin
    w_count_flat = '0;
    w_total_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_count_flat[i*CW +: CW] = w_count[i];
      w_total_next             = w_total_next + TW'(w_count_next[i]);
    end
  end

  assign w_all_zero = &w_lane_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_advance = 1'b1;
        if (w_all_zero) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Total tracks the lanes' next counts so it is already consistent when DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total  <= '0;
      r_cycles <= '0;
    end else if (w_load) begin
      r_total  <= '0;
      r_cycles <= '0;
    end else if (w_advance) begin
      r_total  <= w_total_next;
      r_cycles <= r_cycles + YW'(1);
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.out_count  = w_count_flat;
  assign bus.out_total  = r_total;
  assign bus.out_cycles = r_cycles;

endmodule

// File: tb/tb_popcount_serial_multi.sv
// tb/tb_popcount_serial_multi.sv - self-checking bench for popcount_serial_multi across several parameter sets
module tb_popcount_serial_multi;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_o = 1'b0;
  always #5 clk = ~clk;

  popcount_serial_multi_if #(.WIDTH(8), .CHANNELS(2), .STEP(1)) ifa ();
  popcount_serial_multi_if #(.WIDTH(8), .CHANNELS(2), .STEP(2)) ifb ();
  popcount_serial_multi_if #(.WIDTH(5), .CHANNELS(2), .STEP(2)) ifc ();
  popcount_serial_multi_if #(.WIDTH(8), .CHANNELS(4), .STEP(3)) ifd ();

  popcount_serial_multi #(.WIDTH(8), .CHANNELS(2), .STEP(1)) u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  popcount_serial_multi #(.WIDTH(8), .CHANNELS(2), .STEP(2)) u_b (.clk(clk), .rst(rst_o), .bus(ifb.slave));
  popcount_serial_multi #(.WIDTH(5), .CHANNELS(2), .STEP(2)) u_c (.clk(clk), .rst(rst_o), .bus(ifc.slave));
  popcount_serial_multi #(.WIDTH(8), .CHANNELS(4), .STEP(3)) u_d (.clk(clk), .rst(rst_o), .bus(ifd.slave));

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][7:0] cnt;
    logic [7:0]      tot;
    logic [7:0]      cyc;
  } exp_t;

  // Expected result straight from the rules: ones per lane, and ceil((h+1)/step) cycles.
  function automatic exp_t model(input logic [63:0] d, input int w, input int ch, input int st);
    exp_t e;
    int   h;
    e = '0;
    h = -1;
    for (int l = 0; l < ch; l++) begin
      for (int b = 0; b < w; b++) begin
        if (d[l*w + b]) begin
          e.cnt[l] = e.cnt[l] + 8'd1;
          e.tot    = e.tot + 8'd1;
          if (b > h) h = b;
        end
      end
    end
    e.cyc = (h < 0) ? 8'd1 : 8'((h + st) / st);
    return e;
  endfunction

  logic [15:0] qa[$];
  logic [31:0] qd[$];
  int   a_wait = 0, d_wait = 0, d_results = 0;
  bit   a_seen = 0, d_seen = 0;
  exp_t ea, ed;

  always @(negedge clk) begin
    if (rst_a) begin
      qa.delete();
      a_seen = 0;
      a_wait = 0;
    end else begin
      if (ifa.out_valid) begin
        if (qa.size() == 0) begin
          chk("a_result_without_job", 64'(qa.size()), 64'd1);
        end else begin
          ea = model(64'(qa[0]), 8, 2, 1);
          if (!a_seen) begin
            chk("a_latency", 64'(a_wait), 64'(ea.cyc));
            a_seen = 1;
          end
          for (int i = 0; i < 2; i++)
            chk($sformatf("a_count%0d", i), 64'(ifa.out_count[i*4 +: 4]), 64'(ea.cnt[i][3:0]));
          chk("a_total", 64'(ifa.out_total), 64'(ea.tot[4:0]));
          chk("a_cycles", 64'(ifa.out_cycles), 64'(ea.cyc[3:0]));
          chk("a_in_ready_done", 64'(ifa.in_ready), 64'd0);
          if (ifa.out_ready) begin
            void'(qa.pop_front());
            a_seen = 0;
          end
        end
      end else if (qa.size() != 0) begin
        a_wait++;
      end
      if (ifa.in_valid && ifa.in_ready) begin
        qa.push_back(ifa.in_data);
        a_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_o) begin
      if (ifd.out_valid) begin
        if (qd.size() == 0) begin
          chk("d_result_without_job", 64'(qd.size()), 64'd1);
        end else begin
          ed = model(64'(qd[0]), 8, 4, 3);
          if (!d_seen) begin
            chk("d_latency", 64'(d_wait), 64'(ed.cyc));
            d_seen = 1;
          end
          for (int i = 0; i < 4; i++)
            chk($sformatf("d_count%0d", i), 64'(ifd.out_count[i*4 +: 4]), 64'(ed.cnt[i][3:0]));
          chk("d_total", 64'(ifd.out_total), 64'(ed.tot[5:0]));
          chk("d_cycles", 64'(ifd.out_cycles), 64'(ed.cyc[1:0]));
          if (ifd.out_ready) begin
            void'(qd.pop_front());
            d_seen = 0;
            d_results++;
          end
        end
      end else if (qd.size() != 0) begin
        d_wait++;
      end
      if (ifd.in_valid && ifd.in_ready) begin
        qd.push_back(ifd.in_data);
        d_wait = 0;
      end
    end
  end

  task automatic a_send(input logic [15:0] d);
    bit ok;
    ok = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("a_accept_timeout", 64'(ifa.in_ready), 64'd1);
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
  endtask

  task automatic d_send(input logic [31:0] d);
    bit ok;
    ok = 0;
    ifd.in_valid = 1'b1;
    ifd.in_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ifd.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("d_accept_timeout", 64'(ifd.in_ready), 64'd1);
    @(posedge clk);
    #1 ifd.in_valid = 1'b0;
  endtask

  task automatic a_wait_valid(output int e);
    e = 0;
    while (!ifa.out_valid && e < 100) begin
      @(posedge clk);
      #1 e++;
    end
    if (!ifa.out_valid) chk("a_valid_timeout", 64'(ifa.out_valid), 64'd1);
  endtask

  task automatic a_result(input string nm, input logic [7:0] cnt, input logic [4:0] tot, input logic [3:0] cyc);
    chk({nm, "_count"}, 64'(ifa.out_count), 64'(cnt));
    chk({nm, "_total"}, 64'(ifa.out_total), 64'(tot));
    chk({nm, "_cycles"}, 64'(ifa.out_cycles), 64'(cyc));
  endtask

  task automatic run_a_directed();
    int e;
    // Test 1: 0x0A / 0x07
    a_send(16'h070A);
    chk("t1_in_ready_busy", 64'(ifa.in_ready), 64'd0);
    a_wait_valid(e);
    chk("t1_latency", 64'(e), 64'd4);
    a_result("t1", 8'h32, 5'd5, 4'd4);
    @(posedge clk); #1;
    chk("t1_idle_valid", 64'(ifa.out_valid), 64'd0);
    chk("t1_idle_ready", 64'(ifa.in_ready), 64'd1);
    // Test 2: all zero
    a_send(16'h0000);
    a_wait_valid(e);
    chk("t2_latency", 64'(e), 64'd1);
    a_result("t2", 8'h00, 5'd0, 4'd1);
    @(posedge clk); #1;
    // Test 3: 0xFF / 0x80
    a_send(16'h80FF);
    a_wait_valid(e);
    chk("t3_latency", 64'(e), 64'd8);
    a_result("t3", 8'h18, 5'd9, 4'd8);
    @(posedge clk); #1;
    // Test 4: backpressure with new data pending
    ifa.out_ready = 1'b0;
    a_send(16'h0301);
    a_wait_valid(e);
    chk("t4_latency", 64'(e), 64'd2);
    ifa.in_valid = 1'b1;
    ifa.in_data  = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 64'(ifa.out_valid), 64'd1);
      chk("t4_hold_in_ready", 64'(ifa.in_ready), 64'd0);
      a_result("t4_hold", 8'h21, 5'd3, 4'd2);
    end
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_after_hs_valid", 64'(ifa.out_valid), 64'd0);
    chk("t4_after_hs_ready", 64'(ifa.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("t4_accepted_late", 64'(ifa.in_ready), 64'd0);
    ifa.in_valid = 1'b0;
    a_wait_valid(e);
    chk("t4b_latency", 64'(e), 64'd8);
    a_result("t4b", 8'h88, 5'd16, 4'd8);
    @(posedge clk); #1;
    // Test 5: asynchronous reset mid-BUSY
    a_send(16'h00FF);
    repeat (2) @(posedge clk);
    #2 rst_a = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(ifa.out_valid), 64'd0);
    chk("t5_rst_ready", 64'(ifa.in_ready), 64'd1);
    a_result("t5_rst", 8'h00, 5'd0, 4'd0);
    @(posedge clk);
    #3 rst_a = 1'b0;
    @(posedge clk); #1;
    a_send(16'h0103);
    a_wait_valid(e);
    a_result("t5_after", 8'h12, 5'd3, 4'd2);
    @(posedge clk); #1;
  endtask

  task automatic run_a_random();
    bit done;
    done = 0;
    fork
      begin
        for (int j = 0; j < 30; j++) a_send(16'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ifa.out_ready = 1'($urandom_range(0, 1));
        end
        ifa.out_ready = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    chk("a_random_drained", 64'(qa.size()), 64'd0);
  endtask

  task automatic run_bc();
    int eb, ec;
    chk("b_idle_ready", 64'(ifb.in_ready), 64'd1);
    ifb.in_data  = 16'h80FF;
    ifc.in_data  = 10'h21F;
    ifb.in_valid = 1'b1;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    eb = 0;
    ec = 0;
    for (int k = 1; k <= 20; k++) begin
      if (ifb.out_valid && eb == 0) eb = k - 1;
      if (ifc.out_valid && ec == 0) ec = k - 1;
      @(posedge clk); #1;
    end
    chk("b_latency", 64'(eb), 64'd4);
    chk("b_count", 64'(ifb.out_count), 64'h18);
    chk("b_total", 64'(ifb.out_total), 64'd9);
    chk("b_cycles", 64'(ifb.out_cycles), 64'd4);
    chk("c_latency", 64'(ec), 64'd3);
    chk("c_count", 64'(ifc.out_count), 64'h0D);
    chk("c_total", 64'(ifc.out_total), 64'd6);
    chk("c_cycles", 64'(ifc.out_cycles), 64'd3);
  endtask

  task automatic run_d_random();
    bit done;
    done = 0;
    fork
      begin
        for (int j = 0; j < 40; j++) d_send($urandom);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ifd.out_ready = 1'($urandom_range(0, 1));
        end
        ifd.out_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    chk("d_drained", 64'(qd.size()), 64'd0);
    chk("d_result_count", 64'(d_results), 64'd40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t ep;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b1;

    ep = model(64'h070A, 8, 2, 1);
    chk("pin_t1_cnt0", 64'(ep.cnt[0]), 64'd2);
    chk("pin_t1_cnt1", 64'(ep.cnt[1]), 64'd3);
    chk("pin_t1_cyc", 64'(ep.cyc), 64'd4);
    ep = model(64'h21F, 5, 2, 2);
    chk("pin_w5_tot", 64'(ep.tot), 64'd6);
    chk("pin_w5_cyc", 64'(ep.cyc), 64'd3);
    ep = model(64'h0, 8, 4, 3);
    chk("pin_zero_cyc", 64'(ep.cyc), 64'd1);

    #1;
    rst_a = 1'b1;
    rst_o = 1'b1;
    #1;
    chk("rst_valid", 64'(ifa.out_valid), 64'd0);
    chk("rst_ready", 64'(ifa.in_ready), 64'd1);
    a_result("rst", 8'h00, 5'd0, 4'd0);
    chk("rst_d_total", 64'(ifd.out_total), 64'd0);
    #11;
    rst_a = 1'b0;
    rst_o = 1'b0;
    @(posedge clk); #1;

    fork
      begin
        run_a_directed();
        run_a_random();
      end
      run_bc();
      run_d_random();
    join

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
